// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants for the byte-serial memory controller.
// Holds the FSM state encodings, the MEM access size codes, the owner
// codes, the latched access descriptor and the size-to-last-index decoder.
package mem_ctrl_pkg;

  // FSM state encodings
  localparam logic [2:0] MC_IDLE = 3'd0;
  localparam logic [2:0] MC_RD   = 3'd1;
  localparam logic [2:0] MC_RDW  = 3'd2;
  localparam logic [2:0] MC_WR   = 3'd3;
  localparam logic [2:0] MC_DONE = 3'd4;

  // MEM access size codes (code 3 behaves as a word)
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // Which requester owns the access in flight
  localparam logic MC_OWN_IF  = 1'b0;
  localparam logic MC_OWN_MEM = 1'b1;

  // Access descriptor latched at grant time
  typedef struct packed {
    logic        owner;  // MC_OWN_IF / MC_OWN_MEM
    logic [1:0]  last;   // index of the final byte (n - 1)
    logic [31:0] base;   // first byte address
    logic [31:0] wdata;  // store data, low byte first
  } access_t;

  // Map a size code onto the index of the last byte transferred
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 2'd0;
      MEM_SIZE_H: return 2'd1;
      default:    return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the IF request, MEM request and RAM port signals of
// mem_ctrl. The slave modport is the controller, the master modport is the
// surrounding pipeline plus RAM.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // Instruction fetch side
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_done_o;
  logic [31:0] if_data_o;

  // Data memory stage side
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;

  // Byte-wide RAM port
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i;

  // Status
  logic        busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i,
    output if_done_o, if_data_o,
    output mem_done_o, mem_rdata_o,
    output ram_a_o, ram_dout_o, ram_wr_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    output ram_din_i,
    input  if_done_o, if_data_o,
    input  mem_done_o, mem_rdata_o,
    input  ram_a_o, ram_dout_o, ram_wr_o,
    input  busy_o
  );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller and arbiter. Shares one 8-bit RAM
// port between instruction fetch (always 4 bytes) and the MEM stage
// (1/2/4 bytes, little endian, any alignment). MEM wins arbitration.
// All outputs are registered; busy is decoded from the state register.
// Optional feature: define MEMCTRL_IF_PREEMPT_EN to let a MEM request abort
// an IF fetch that is still issuing read addresses.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic      clk,
  input logic      rst,
  mem_ctrl_if.slave bus
);

  logic [2:0]  state_reg,     state_next;
  logic [1:0]  cnt_reg,       cnt_next;
  access_t     acc_reg,       acc_next;
  logic [31:0] rd_buf_reg,    rd_buf_next;
  logic [31:0] ram_a_reg,     ram_a_next;
  logic [7:0]  ram_dout_reg,  ram_dout_next;
  logic        ram_wr_reg,    ram_wr_next;
  logic        if_done_reg,   if_done_next;
  logic        mem_done_reg,  mem_done_next;
  logic [31:0] if_data_reg,   if_data_next;
  logic [31:0] mem_rdata_reg, mem_rdata_next;

  logic        capture;
  logic [1:0]  cap_idx;
  logic        clear_buf;
  logic        abort;
  logic [1:0]  cnt_inc;
  logic [31:0] addr_inc;

  // Decide which byte lane (if any) takes the RAM read byte this cycle.
  // The RAM answers one cycle late, so in RD lane cnt-1 is captured and RDW
  // captures the final lane.
  always_comb begin
    capture   = 1'b0;
    cap_idx   = 2'd0;
    clear_buf = (state_reg == MC_IDLE);
    if (state_reg == MC_RD && cnt_reg != 2'd0) begin
      capture = 1'b1;
      cap_idx = cnt_reg - 2'd1;
    end else if (state_reg == MC_RDW) begin
      capture = 1'b1;
      cap_idx = acc_reg.last;
    end
  end

  // One assembler per byte lane; lanes never captured stay zero because the
  // buffer is cleared while idle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_buf_next[8*gi +: 8] =
        clear_buf                             ? 8'h00         :
        (capture && cap_idx == 2'(gi))        ? bus.ram_din_i :
                                                rd_buf_reg[8*gi +: 8];
  end

  // Preemption: an IF fetch still issuing addresses yields to MEM.
`ifdef MEMCTRL_IF_PREEMPT_EN
  always_comb begin
    abort = (acc_reg.owner == MC_OWN_IF) && bus.mem_req_i;
  end
`else
  always_comb begin
    abort = 1'b0;
  end
`endif

  // Next byte index and its address (32-bit wrap is natural here)
  always_comb begin
    cnt_inc  = cnt_reg + 2'd1;
    addr_inc = acc_reg.base + {30'd0, cnt_inc};
  end

  // FSM: arbitration, byte sequencing and next values of the output registers.
  // RAM outputs default to zero so IDLE, RDW and DONE drive a quiet port.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    ram_a_next     = 32'd0;
    ram_dout_next  = 8'd0;
    ram_wr_next    = 1'b0;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    if_data_next   = 32'd0;
    mem_rdata_next = 32'd0;

    case (state_reg)
      MC_IDLE: begin
        if (bus.mem_req_i) begin
          acc_next.owner = MC_OWN_MEM;
          acc_next.last  = size_last(bus.mem_size_i);
          acc_next.base  = bus.mem_addr_i;
          acc_next.wdata = bus.mem_wdata_i;
          cnt_next       = 2'd0;
          ram_a_next     = bus.mem_addr_i;
          if (bus.mem_we_i) begin
            state_next    = MC_WR;
            ram_wr_next   = 1'b1;
            ram_dout_next = bus.mem_wdata_i[7:0];
          end else begin
            state_next    = MC_RD;
          end
        end else if (bus.if_req_i) begin
          acc_next.owner = MC_OWN_IF;
          acc_next.last  = 2'd3;
          acc_next.base  = bus.if_addr_i;
          acc_next.wdata = 32'd0;
          cnt_next       = 2'd0;
          ram_a_next     = bus.if_addr_i;
          state_next     = MC_RD;
        end
      end

      MC_RD: begin
        if (abort) begin
          state_next = MC_IDLE;
        end else if (cnt_reg == acc_reg.last) begin
          state_next = MC_RDW;
        end else begin
          cnt_next   = cnt_inc;
          ram_a_next = addr_inc;
        end
      end

      MC_RDW: begin
        state_next = MC_DONE;
        if (acc_reg.owner == MC_OWN_IF) begin
          if_done_next = 1'b1;
          if_data_next = rd_buf_next;
        end else begin
          mem_done_next  = 1'b1;
          mem_rdata_next = rd_buf_next;
        end
      end

      MC_WR: begin
        if (cnt_reg == acc_reg.last) begin
          state_next    = MC_DONE;
          mem_done_next = 1'b1;
        end else begin
          cnt_next      = cnt_inc;
          ram_a_next    = addr_inc;
          ram_wr_next   = 1'b1;
          ram_dout_next = acc_reg.wdata[{cnt_inc, 3'b000} +: 8];
        end
      end

      MC_DONE: begin
        state_next = MC_IDLE;
      end

      default: begin
        state_next = MC_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= MC_IDLE;
      cnt_reg       <= 2'd0;
      acc_reg       <= '0;
      rd_buf_reg    <= 32'd0;
      ram_a_reg     <= 32'd0;
      ram_dout_reg  <= 8'd0;
      ram_wr_reg    <= 1'b0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      if_data_reg   <= 32'd0;
      mem_rdata_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      rd_buf_reg    <= rd_buf_next;
      ram_a_reg     <= ram_a_next;
      ram_dout_reg  <= ram_dout_next;
      ram_wr_reg    <= ram_wr_next;
      if_done_reg   <= if_done_next;
      mem_done_reg  <= mem_done_next;
      if_data_reg   <= if_data_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  assign bus.ram_a_o     = ram_a_reg;
  assign bus.ram_dout_o  = ram_dout_reg;
  assign bus.ram_wr_o    = ram_wr_reg;
  assign bus.if_done_o   = if_done_reg;
  assign bus.if_data_o   = if_data_reg;
  assign bus.mem_done_o  = mem_done_reg;
  assign bus.mem_rdata_o = mem_rdata_reg;
  assign bus.busy_o      = (state_reg != MC_IDLE);

endmodule
